// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: fetch FSM state encoding and the
// datapath constants reused by the PC, fetch and decode stages.
package cpu_pkg;

    localparam int          ADDR_W    = 32;
    localparam int          DATA_W    = 32;
    // addi x0, x0, 0 -- a harmless instruction presented on a fetch error
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,  // nothing outstanding
        REQ   = 2'd1,  // memory request raised, waiting for mem_ack
        HOLD  = 2'd2,  // instruction presented, waiting for instr_ready
        DRAIN = 2'd3   // flushed request still owed an ack; data discarded
    } fetch_state_t;

    // An instruction address is word aligned when its two low bits are zero
    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return (addr_lsb != 2'b00);
    endfunction

endpackage

// File: rtl/imem_fetch_unit.sv
// Instruction fetch unit: takes addresses from the PC stage, fetches the
// word from instruction memory over a req/ack handshake and presents it to
// decode with valid/ready.
//
// Optional build macro: IMEM_MISALIGN_CHECK_EN
//   defined   -> a misaligned accepted address skips memory and is presented
//                directly as NOP_INSTR with instr_err=1
//   undefined -> every accepted address is fetched, instr_err is always 0
//
// Handshakes:
//   addr  : a transfer happens in a cycle where addr_valid && addr_ready.
//           addr_ready is combinational and never depends on addr_valid.
//   instr : a transfer happens in a cycle where instr_valid && instr_ready;
//           instr_* hold stable while instr_valid=1 and instr_ready=0,
//           unless a flush withdraws them.
//   mem   : mem_req rises and stays high (with mem_addr stable) until the
//           cycle mem_ack is seen; it is never withdrawn, even by a flush.
//           mem_rdata is sampled in the mem_ack cycle.
module imem_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                 ADDR_W    = cpu_pkg::ADDR_W,
    parameter int                 DATA_W    = cpu_pkg::DATA_W,
    parameter logic [DATA_W-1:0]  NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic              clk,
    input  logic              rst,          // asynchronous, active low

    // PC stage
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              addr_valid,
    output logic              addr_ready,
    input  logic              flush,

    // Instruction memory
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,

    // Decode stage
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_addr,
    output logic              instr_err,

    // Debug view of the fetch FSM
    output fetch_state_t      dbg_state
);

    fetch_state_t      r_state;
    fetch_state_t      w_next_state;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_instr_data;
    logic [ADDR_W-1:0] r_instr_addr;
    logic              r_instr_err;

    logic              w_accept;
    logic              w_misaligned;
    logic              w_mem_capture;

    // Ready when idle, or when the held instruction leaves this cycle; a
    // flush always blocks new addresses for the cycle it is asserted.
    assign addr_ready = !flush && ((r_state == IDLE) ||
                                   ((r_state == HOLD) && instr_ready));
    assign w_accept   = addr_valid && addr_ready;

`ifdef IMEM_MISALIGN_CHECK_EN
    assign w_misaligned = is_misaligned(addr_in[1:0]);
`else
    assign w_misaligned = 1'b0;
`endif

    // Memory data is kept only for a live (unflushed) request in REQ
    assign w_mem_capture = (r_state == REQ) && mem_ack && !flush;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_mem_addr   <= '0;
            r_instr_data <= '0;
            r_instr_addr <= '0;
            r_instr_err  <= 1'b0;
        end else begin
            r_state <= w_next_state;

            if (w_accept) begin
                r_mem_addr <= addr_in;
            end

            // Misaligned accept bypasses memory (never true in default build)
            if (w_accept && w_misaligned) begin
                r_instr_data <= NOP_INSTR;
                r_instr_addr <= addr_in;
                r_instr_err  <= 1'b1;
            end else if (w_mem_capture) begin
                r_instr_data <= mem_rdata;
                r_instr_addr <= r_mem_addr;
                r_instr_err  <= 1'b0;
            end
        end
    end

    // Next-state logic; flush takes priority except that an ack always
    // retires the single outstanding memory request.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = w_misaligned ? HOLD : REQ;
                end
            end
            REQ: begin
                if (flush) begin
                    w_next_state = mem_ack ? IDLE : DRAIN;
                end else if (mem_ack) begin
                    w_next_state = HOLD;
                end
            end
            HOLD: begin
                if (flush) begin
                    w_next_state = IDLE;
                end else if (instr_ready) begin
                    if (w_accept) begin
                        w_next_state = w_misaligned ? HOLD : REQ;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (mem_ack) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Outputs decoded from registered state and registered datapath
    always_comb begin
        mem_req     = (r_state == REQ) || (r_state == DRAIN);
        instr_valid = (r_state == HOLD);
        mem_addr    = r_mem_addr;
        instr_data  = r_instr_data;
        instr_addr  = r_instr_addr;
        instr_err   = r_instr_err;
        dbg_state   = r_state;
    end

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Self-checking bench for imem_fetch_unit: directed scenarios followed by a
// randomized phase scored against a transaction-level expectation queue.
// Honours IMEM_MISALIGN_CHECK_EN for the misalignment scenario.
module tb_imem_fetch_unit;
    import cpu_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  addr_in;
    logic         addr_valid;
    logic         addr_ready;
    logic         flush;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_ack;
    logic [31:0]  mem_rdata;
    logic         instr_valid;
    logic         instr_ready;
    logic [31:0]  instr_data;
    logic [31:0]  instr_addr;
    logic         instr_err;
    fetch_state_t dbg_state;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    imem_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .addr_in     (addr_in),
        .addr_valid  (addr_valid),
        .addr_ready  (addr_ready),
        .flush       (flush),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_data  (instr_data),
        .instr_addr  (instr_addr),
        .instr_err   (instr_err),
        .dbg_state   (dbg_state)
    );

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_req"},     32'(mem_req),     32'd0);
        check({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
        check({tag, "_instr_err"},   32'(instr_err),   32'd0);
        check({tag, "_mem_addr"},    mem_addr,         32'd0);
        check({tag, "_instr_data"},  instr_data,       32'd0);
        check({tag, "_instr_addr"},  instr_addr,       32'd0);
    endtask

    // Memory contents: a fixed scramble of the address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // ---------------- stimulus and checking ----------------
    initial begin
        logic [31:0] e;
        logic [31:0] prev_addr;
        logic        prev_pend;
        int          handshakes;

        rst = 1'b0; addr_in = '0; addr_valid = 1'b0; flush = 1'b0;
        mem_ack = 1'b0; mem_rdata = '0; instr_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        check_all_zero("reset");
        check("reset_state", 32'(dbg_state), 32'(IDLE));
        check("reset_addr_ready", 32'(addr_ready), 32'd1);
        rst = 1'b1;
        tick();

        // Basic fetch: accept 0x4, ack two cycles later
        addr_valid = 1'b1; addr_in = 32'h4;
        #1 check("basic_addr_ready", 32'(addr_ready), 32'd1);
        tick();
        addr_valid = 1'b0;
        #1 check("basic_mem_req", 32'(mem_req), 32'd1);
        check("basic_mem_addr", mem_addr, 32'h4);
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h00A0_0093;
        #1 check("basic_no_valid_yet", 32'(instr_valid), 32'd0);
        tick();
        mem_ack = 1'b0; mem_rdata = '0;
        #1 check("basic_instr_valid", 32'(instr_valid), 32'd1);
        check("basic_instr_data", instr_data, 32'h00A0_0093);
        check("basic_instr_addr", instr_addr, 32'h4);
        check("basic_instr_err", 32'(instr_err), 32'd0);
        check("basic_req_dropped", 32'(mem_req), 32'd0);

        // Backpressure: 5 cycles with instr_ready=0 in HOLD
        addr_valid = 1'b1; addr_in = 32'h8;
        for (int i = 0; i < 5; i++) begin
            #1 check("bp_addr_ready", 32'(addr_ready), 32'd0);
            check("bp_valid", 32'(instr_valid), 32'd1);
            check("bp_data", instr_data, 32'h00A0_0093);
            check("bp_addr", instr_addr, 32'h4);
            check("bp_no_req", 32'(mem_req), 32'd0);
            tick();
        end
        instr_ready = 1'b1;
        #1 check("bp_release_addr_ready", 32'(addr_ready), 32'd1);
        tick();
        instr_ready = 1'b0; addr_valid = 1'b0;
        #1 check("bp_next_mem_req", 32'(mem_req), 32'd1);
        check("bp_next_mem_addr", mem_addr, 32'h8);
        check("bp_next_valid_low", 32'(instr_valid), 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
        tick();
        mem_ack = 1'b0;
        #1 check("bp_second_data", instr_data, 32'h1111_1111);
        check("bp_second_addr", instr_addr, 32'h8);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        #1 check("bp_consumed", 32'(instr_valid), 32'd0);

        // Flush in REQ, ack three cycles after the flush
        addr_valid = 1'b1; addr_in = 32'h10;
        tick();
        addr_valid = 1'b0; flush = 1'b1;
        #1 check("flreq_addr_ready", 32'(addr_ready), 32'd0);
        check("flreq_mem_req", 32'(mem_req), 32'd1);
        tick();
        flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1 check("drain_mem_req", 32'(mem_req), 32'd1);
            check("drain_valid", 32'(instr_valid), 32'd0);
            check("drain_addr_ready", 32'(addr_ready), 32'd0);
            check("drain_mem_addr", mem_addr, 32'h10);
            tick();
        end
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        #1 check("drain_ack_mem_req", 32'(mem_req), 32'd1);
        check("drain_ack_addr_ready", 32'(addr_ready), 32'd0);
        tick();
        mem_ack = 1'b0; mem_rdata = '0;
        #1 check("drain_done_req", 32'(mem_req), 32'd0);
        check("drain_done_valid", 32'(instr_valid), 32'd0);
        check("drain_done_addr_ready", 32'(addr_ready), 32'd1);
        check("drain_data_discarded", instr_data, 32'h1111_1111);
        tick();

        // Flush coincident with mem_ack in REQ
        addr_valid = 1'b1; addr_in = 32'h20;
        tick();
        addr_valid = 1'b0; flush = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        tick();
        flush = 1'b0; mem_ack = 1'b0;
        #1 check("flack_valid", 32'(instr_valid), 32'd0);
        check("flack_req", 32'(mem_req), 32'd0);
        check("flack_addr_ready", 32'(addr_ready), 32'd1);
        check("flack_data_dropped", instr_data, 32'h1111_1111);

        // Flush in HOLD with instr_ready high and a waiting address
        addr_valid = 1'b1; addr_in = 32'h24;
        tick();
        addr_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h2222_2222;
        tick();
        mem_ack = 1'b0; flush = 1'b1; instr_ready = 1'b1;
        addr_valid = 1'b1; addr_in = 32'h28;
        #1 check("flhold_valid_before", 32'(instr_valid), 32'd1);
        check("flhold_addr_ready", 32'(addr_ready), 32'd0);
        tick();
        flush = 1'b0; instr_ready = 1'b0; addr_valid = 1'b0;
        #1 check("flhold_valid_after", 32'(instr_valid), 32'd0);
        check("flhold_no_req", 32'(mem_req), 32'd0);

        // Flush in IDLE blocks acceptance
        flush = 1'b1; addr_valid = 1'b1; addr_in = 32'h2C;
        #1 check("flidle_addr_ready", 32'(addr_ready), 32'd0);
        tick();
        flush = 1'b0; addr_valid = 1'b0;
        #1 check("flidle_no_req", 32'(mem_req), 32'd0);
        tick();

        // Asynchronous reset while a request is outstanding
        addr_valid = 1'b1; addr_in = 32'h30;
        tick();
        addr_valid = 1'b0;
        #1 check("rstreq_pre", 32'(mem_req), 32'd1);
        rst = 1'b0;
        #1 check_all_zero("rst_in_req");
        tick();
        rst = 1'b1;
        tick();

        // Asynchronous reset while holding an instruction
        addr_valid = 1'b1; addr_in = 32'h34;
        tick();
        addr_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h3333_3333;
        tick();
        mem_ack = 1'b0;
        #1 check("rsthold_pre", 32'(instr_valid), 32'd1);
        rst = 1'b0;
        #1 check_all_zero("rst_in_hold");
        tick();
        rst = 1'b1;
        tick();

        // Misaligned address 0x6
        addr_valid = 1'b1; addr_in = 32'h6;
        tick();
        addr_valid = 1'b0;
`ifdef IMEM_MISALIGN_CHECK_EN
        #1 check("mis_no_req", 32'(mem_req), 32'd0);
        check("mis_valid", 32'(instr_valid), 32'd1);
        check("mis_err", 32'(instr_err), 32'd1);
        check("mis_data", instr_data, 32'h0000_0013);
        check("mis_addr", instr_addr, 32'h6);
`else
        #1 check("mis_req", 32'(mem_req), 32'd1);
        check("mis_mem_addr", mem_addr, 32'h6);
        check("mis_err_low", 32'(instr_err), 32'd0);
        mem_ack = 1'b1; mem_rdata = mem_word(32'h6);
        tick();
        mem_ack = 1'b0;
        #1 check("mis_valid", 32'(instr_valid), 32'd1);
        check("mis_data", instr_data, mem_word(32'h6));
        check("mis_addr", instr_addr, 32'h6);
        check("mis_err_after", 32'(instr_err), 32'd0);
`endif
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;

        // Randomized phase: every presented instruction must be the oldest
        // accepted, unflushed address with its memory word.
        exp_q.delete();
        prev_pend  = 1'b0;
        prev_addr  = '0;
        handshakes = 0;
        for (int c = 0; c < 800; c++) begin
            if (prev_pend) begin
                check("rnd_req_held", 32'(mem_req), 32'd1);
                check("rnd_addr_stable", mem_addr, prev_addr);
            end
            addr_valid  = ($urandom_range(0, 1) == 1);
            addr_in     = $urandom & 32'hFFFF_FFFC;
            instr_ready = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 19) == 0);
            mem_ack     = ($urandom_range(0, 2) == 0);
            mem_rdata   = mem_req ? mem_word(mem_addr) : $urandom;
            #1;
            if (flush) begin
                check("rnd_flush_blocks", 32'(addr_ready), 32'd0);
                exp_q.delete();
            end else if (instr_valid && instr_ready) begin
                if (exp_q.size() == 0) begin
                    check("rnd_unexpected_instr", 32'(instr_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rnd_instr_addr", instr_addr, e);
                    check("rnd_instr_data", instr_data, mem_word(e));
                    check("rnd_instr_err", 32'(instr_err), 32'd0);
                    handshakes++;
                end
            end
            if (addr_valid && addr_ready) begin
                check("rnd_single_outstanding", 32'(exp_q.size()), 32'd0);
                exp_q.push_back(addr_in);
            end
            prev_pend = mem_req && !mem_ack;
            prev_addr = mem_addr;
            tick();
        end
        check("rnd_activity", 32'(handshakes > 20), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
